// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: width, taps, next-state function
// and checker state encoding (also used by the generator).
package lfsr_pkg;

  localparam int LFSR_W = 4;
  localparam int TAP_HI = 3;
  localparam int TAP_LO = 2;

  typedef logic [LFSR_W-1:0] lfsr_t;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  // x^4 + x^3 + 1, shift left, feedback into bit 0
  function automatic lfsr_t lfsr_next_f(input lfsr_t s);
    return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational LFSR next-state.
// Ports: s_i current state, s_o next state.
module lfsr_next
  import lfsr_pkg::*;
(
  input  lfsr_t s_i,
  output lfsr_t s_o
);

  assign s_o = lfsr_next_f(s_i);

endmodule

// File: rtl/lfsr_checker.sv
// LFSR sequence checker: search for lock, flywheel while locked.
// Ports: clk, async_rst (n), sync_rst, data_in/vld, locked, err_*.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             async_rst,
  input  logic             sync_rst,
  input  logic [3:0]       data_in,
  input  logic             data_vld,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  chk_state_e       state_q, state_d;
  lfsr_t            ref_q, ref_d;
  logic             ref_vld_q, ref_vld_d;
  logic [MW-1:0]    match_q, match_d;
  lfsr_t            pred_q, pred_d;
  logic [LW-1:0]    miss_q, miss_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             locked_q, locked_d;

  lfsr_t ref_nxt;
  lfsr_t pred_nxt;
  logic  ref_hit;
  logic  pred_hit;

  lfsr_next u_ref_next (
    .s_i (ref_q),
    .s_o (ref_nxt)
  );

  lfsr_next u_pred_next (
    .s_i (pred_q),
    .s_o (pred_nxt)
  );

  // all-zero word is the lock-up state: never a match
  assign ref_hit  = (data_in != '0) &&
                    (data_in == ref_nxt);
  assign pred_hit = (data_in != '0) &&
                    (data_in == pred_nxt);

  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    ref_vld_d   = ref_vld_q;
    match_d     = match_q;
    pred_d      = pred_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (data_vld) begin
      unique case (state_q)
        SEARCH: begin
          ref_d     = data_in;
          ref_vld_d = 1'b1;
          // first sample after entry only seeds ref
          if (ref_vld_q) begin
            if (!ref_hit) begin
              match_d = '0;
            end else if (match_q ==
                         MW'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
              match_d = '0;
              miss_d  = '0;
              pred_d  = data_in;
            end else begin
              match_d = match_q + MW'(1);
            end
          end
        end
        LOCKED: begin
          // flywheel: never resync from data_in
          pred_d = pred_nxt;
          if (pred_hit) begin
            miss_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != '1)
              err_cnt_d = err_cnt_q + ERR_W'(1);
            if (miss_q == LW'(LOSS_CNT - 1)) begin
              state_d   = SEARCH;
              miss_d    = '0;
              match_d   = '0;
              ref_vld_d = 1'b0;
            end else begin
              miss_d = miss_q + LW'(1);
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    if (sync_rst) begin
      state_d     = SEARCH;
      ref_d       = '0;
      ref_vld_d   = 1'b0;
      match_d     = '0;
      pred_d      = '0;
      miss_d      = '0;
      err_pulse_d = 1'b0;
      err_cnt_d   = '0;
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge async_rst) begin
    if (!async_rst) begin
      state_q     <= SEARCH;
      ref_q       <= '0;
      ref_vld_q   <= 1'b0;
      match_q     <= '0;
      pred_q      <= '0;
      miss_q      <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      ref_vld_q   <= ref_vld_d;
      match_q     <= match_d;
      pred_q      <= pred_d;
      miss_q      <= miss_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      locked_q    <= locked_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker (ERR_W 8 and 2 copies).
// Model uses the period-15 sequence table, not shift logic.
module tb_lfsr_checker;

  localparam int LOCK_CNT = 3;
  localparam int LOSS_CNT = 2;

  logic       clk = 1'b0;
  logic       async_rst = 1'b0;
  logic       sync_rst = 1'b0;
  logic       data_vld = 1'b0;
  logic [3:0] data_in = 4'd0;

  logic       lk8, pl8, lk2, pl2;
  logic [7:0] c8;
  logic [1:0] c2;

  lfsr_checker #(
    .LOCK_CNT (LOCK_CNT),
    .LOSS_CNT (LOSS_CNT),
    .ERR_W    (8)
  ) u8 (
    .clk       (clk),
    .async_rst (async_rst),
    .sync_rst  (sync_rst),
    .data_in   (data_in),
    .data_vld  (data_vld),
    .locked    (lk8),
    .err_pulse (pl8),
    .err_cnt   (c8)
  );

  lfsr_checker #(
    .LOCK_CNT (LOCK_CNT),
    .LOSS_CNT (LOSS_CNT),
    .ERR_W    (2)
  ) u2 (
    .clk       (clk),
    .async_rst (async_rst),
    .sync_rst  (sync_rst),
    .data_in   (data_in),
    .data_vld  (data_vld),
    .locked    (lk2),
    .err_pulse (pl2),
    .err_cnt   (c2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lk;
    int pl;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  int seq_tbl [15] = '{1, 2, 4, 9, 3, 6, 13,
                       10, 5, 11, 7, 15, 14, 12, 8};

  int m_lk, m_have, m_ref, m_mc;
  int m_pred, m_miss, m_err, m_pl;
  int gi;

  function automatic int nxt(input int s);
    for (int i = 0; i < 15; i++)
      if (seq_tbl[i] == s) return seq_tbl[(i + 1) % 15];
    return -1;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lk = 0; m_have = 0; m_ref = 0; m_mc = 0;
    m_pred = 0; m_miss = 0; m_err = 0; m_pl = 0;
  endtask

  task automatic model_step(input bit v, input int d,
                            input bit sr);
    bit ok;
    m_pl = 0;
    if (sr) begin
      model_reset();
    end else if (v) begin
      if (m_lk == 0) begin
        if (m_have == 0) begin
          m_have = 1;
        end else begin
          ok = (d != 0) && (d == nxt(m_ref));
          if (!ok) m_mc = 0;
          else begin
            m_mc++;
            if (m_mc == LOCK_CNT) begin
              m_lk = 1; m_pred = d;
              m_mc = 0; m_miss = 0;
            end
          end
        end
        m_ref = d;
      end else begin
        ok = (d != 0) && (d == nxt(m_pred));
        m_pred = nxt(m_pred);
        if (ok) m_miss = 0;
        else begin
          m_pl = 1;
          m_err++;
          m_miss++;
          if (m_miss == LOSS_CNT) begin
            m_lk = 0; m_have = 0;
            m_mc = 0; m_miss = 0;
          end
        end
      end
    end
  endtask

  task automatic step(input bit v, input logic [3:0] d,
                      input bit sr);
    data_vld = v;
    data_in  = d;
    sync_rst = sr;
    @(posedge clk);
    model_step(v, int'(d), sr);
    sb.push_back('{m_lk, m_pl, m_err});
    #1;
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 4'(seq_tbl[gi]), 1'b0);
      gi = (gi + 1) % 15;
    end
  endtask

  task automatic bad_word();
    step(1'b1, 4'(seq_tbl[gi]) ^ 4'b0101, 1'b0);
    gi = (gi + 1) % 15;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_lk8"}, int'(lk8), 0);
    chk({nm, "_pl8"}, int'(pl8), 0);
    chk({nm, "_c8"},  int'(c8),  0);
    chk({nm, "_lk2"}, int'(lk2), 0);
    chk({nm, "_c2"},  int'(c2),  0);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("locked8", int'(lk8), e.lk);
      chk("pulse8",  int'(pl8), e.pl);
      chk("cnt8",    int'(c8),  sat(e.cnt, 255));
      chk("locked2", int'(lk2), e.lk);
      chk("pulse2",  int'(pl2), e.pl);
      chk("cnt2",    int'(c2),  sat(e.cnt, 3));
    end
  end

  initial begin
    int r;
    model_reset();
    gi = 0;
    #3;
    chk_zero("rst");
    @(negedge clk);
    #1;
    async_rst = 1'b1;

    clean(40);

    while (gi != 5) clean(1);
    step(1'b1, 4'b0111, 1'b0);
    gi = (gi + 1) % 15;
    clean(5);

    repeat (5) step(1'b0, 4'($urandom), 1'b0);
    clean(6);

    bad_word();
    bad_word();
    clean(8);

    repeat (6) begin
      bad_word();
      clean(1);
    end

    step(1'b1, 4'(seq_tbl[gi]), 1'b1);
    gi = (gi + 1) % 15;
    clean(10);

    @(negedge clk);
    #1;
    async_rst = 1'b0;
    #1;
    chk_zero("arst");
    model_reset();
    #1;
    async_rst = 1'b1;
    clean(8);

    repeat (20) step(1'b1, 4'd0, 1'b0);
    clean(6);

    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        step(1'b1, 4'(seq_tbl[gi]), 1'b1);
        gi = (gi + 1) % 15;
      end else if (r < 22) begin
        step(1'b0, 4'($urandom), 1'b0);
      end else if (r < 30) begin
        step(1'b1, 4'($urandom), 1'b0);
        gi = (gi + 1) % 15;
      end else if (r < 32) begin
        gi = $urandom_range(0, 14);
        clean(1);
      end else begin
        clean(1);
      end
    end

    repeat (3) @(negedge clk);
    #1;
    chk("drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter LOCK_CNT, default 3: consecutive matching samples required in SEARCH to declare lock.
REQ-002 Parameter LOSS_CNT, default 2: consecutive mismatching samples in LOCKED that force return to SEARCH.
REQ-003 Parameter ERR_W, default 8: width of the error counter.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 async_rst  input  1  asynchronous, active-low reset.
REQ-006 sync_rst  input  1  synchronous, active-high clear, sampled on clk.
REQ-007 data_in  input  4  received 4-bit LFSR state word (generator cnt_out).
REQ-008 data_vld  input  1  data_in valid this cycle; invalid cycles leave all state unchanged.
REQ-009 locked  output  1  registered; high while FSM is in LOCKED.
REQ-010 err_pulse  output  1  registered; one-cycle pulse per mismatching valid sample while LOCKED.
REQ-011 err_cnt  output  ERR_W  registered; saturating count of mismatches while LOCKED.

Function
REQ-012 Sequence SHALL be next(s) = {s[2:0], s[3]^s[2]} (x^4+x^3+1, period 15); from 0001: 0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000, repeat.
REQ-013 FSM states SHALL be SEARCH and LOCKED; reset state SEARCH.
REQ-014 SEARCH: first valid sample after entry only loads ref register; no comparison.
REQ-015 SEARCH: each later valid sample compared with next(ref); match increments match counter, mismatch clears it; ref always loads data_in.
REQ-016 data_in = 0000 SHALL always count as mismatch (lock-up word) in both states.
REQ-017 When match counter reaches LOCK_CNT, FSM SHALL enter LOCKED on that edge; locked high from the following cycle; predictor loaded with data_in.
REQ-018 LOCKED (flywheel): each valid sample compared with next(pred); pred SHALL advance to next(pred) regardless of match, never reloaded from data_in.
REQ-019 LOCKED mismatch: err_pulse high the following cycle for exactly one cycle; err_cnt +1, saturating at 2^ERR_W-1 (no wrap).
REQ-020 LOCKED match clears the consecutive-mismatch counter.
REQ-021 LOSS_CNT consecutive mismatches: FSM SHALL return to SEARCH on that edge (that mismatch still pulses and counts); match counter cleared; next valid sample treated per REQ-014.
REQ-022 SEARCH mismatches SHALL NOT pulse err_pulse or change err_cnt.
REQ-023 err_cnt SHALL hold its value across SEARCH/LOCKED transitions; cleared only by reset or sync_rst.
REQ-024 Gaps in data_vld SHALL NOT advance pred or any counter.

Reset
REQ-025 async_rst low SHALL immediately force SEARCH, locked=0, err_pulse=0, err_cnt=0, all internal counters/registers 0.
REQ-026 sync_rst high at a rising edge SHALL produce the identical state; it overrides data_vld that cycle.
REQ-027 Reset mid-lock SHALL drop locked on assertion (async) or the next edge (sync); re-lock requires full LOCK_CNT sequence.

Structure
REQ-028 Shared package lfsr_pkg SHALL hold LFSR width (4), tap positions, next-state function and SEARCH/LOCKED state encoding, shared with the generator.
REQ-029 One combinational sub-module lfsr_next (4-bit in, 4-bit next-state out) SHALL be instantiated twice: for ref and for pred.

Verification
REQ-030 Reset release, then clean stream from 0001 with data_vld=1 -> locked high the cycle after the 4th sample (1001 at 3 matches); err_cnt stays 0 over 40 samples.
REQ-031 While locked, replace one sample 0110 with 0111 -> err_pulse one cycle, err_cnt=1, locked stays high, next sample 1101 compares clean.
REQ-032 While locked, inject two consecutive wrong words -> err_cnt+2, locked low after second; clean stream thereafter re-locks after 1+LOCK_CNT samples.
REQ-033 Feed 0000 repeatedly from reset -> locked never asserts, err_cnt remains 0.
REQ-034 ERR_W=2, locked, every other sample corrupted -> err_cnt saturates at 3, no wrap.
REQ-035 Locked, data_vld low for 5 cycles mid-stream then stream resumes at next word -> no error; then sync_rst 1 cycle -> locked=0, err_cnt=0 next cycle.
